// File: rtl/cpu_6502_rmw_seq.sv
// Read-modify-write sequencer: READ -> DUMMY_WR -> WRITE -> DONE, o_done 4 cycles after start with no stalls.
// Backpressure: i_mem_ready low holds the current access (strobe, address, data) for that cycle.

typedef enum logic [3:0] {
  ALU_AND = 4'd0,
  ALU_ORA = 4'd1,
  ALU_EOR = 4'd2,
  ALU_ADC = 4'd3,
  ALU_SBC = 4'd4,
  ALU_ASL = 4'd5,
  ALU_LSR = 4'd6,
  ALU_ROL = 4'd7,
  ALU_ROR = 4'd8
} alu_op_t;

module cpu_6502_rmw_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_addr,
  input  logic        i_carry,
  output logic        o_busy,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  output alu_op_t     o_alu_op,
  output logic [7:0]  o_alu_lhs,
  output logic [7:0]  o_alu_rhs,
  output logic        o_alu_carry,
  output logic        o_alu_bcd,
  input  logic [7:0]  i_alu_result,
  input  logic        i_alu_carry,
  output logic        o_done,
  output logic [7:0]  o_result,
  output logic        o_flag_n,
  output logic        o_flag_z,
  output logic        o_flag_c,
  output logic        o_update_c
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DUMMY_WR, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic        cin_q, cin_d;
  logic [7:0]  operand_q, operand_d;
  logic [7:0]  alu_res_q, alu_res_d;
  logic        alu_cout_q, alu_cout_d;
  logic        busy_q, busy_d, rd_q, rd_d, wr_q, wr_d, done_q, done_d;
  logic [7:0]  wdata_q, wdata_d;
  alu_op_t     alu_op_q, alu_op_d;
  logic [7:0]  alu_lhs_q, alu_lhs_d, alu_rhs_q, alu_rhs_d;
  logic        alu_carry_q, alu_carry_d;
  logic [7:0]  result_q, result_d;
  logic        flag_n_q, flag_n_d, flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic        update_c_q, update_c_d;
  logic        is_shift;

  assign is_shift = (op_q <= 3'd3);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cin_d      = cin_q;
    operand_d  = operand_q;
    alu_res_d  = alu_res_q;
    alu_cout_d = alu_cout_q;
    result_d   = result_q;
    flag_n_d   = flag_n_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    update_c_d = update_c_q;

    case (state_q)
      S_IDLE: begin
        if (i_start && (i_op <= 3'd5)) begin
          state_d = S_READ;
          op_d    = i_op;
          addr_d  = i_addr;
          cin_d   = i_carry;
        end
      end
      S_READ: begin
        if (i_mem_ready) begin
          operand_d = i_mem_rdata;
          state_d   = S_DUMMY_WR;
        end
      end
      S_DUMMY_WR: begin
        if (i_mem_ready) begin
          alu_res_d  = i_alu_result;
          alu_cout_d = i_alu_carry;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_mem_ready) begin
          state_d    = S_DONE;
          result_d   = alu_res_q;
          flag_n_d   = alu_res_q[7];
          flag_z_d   = (alu_res_q == 8'h00);
          // INC/DEC leave C untouched, so the flag logic sees the old value
          flag_c_d   = is_shift ? alu_cout_q : cin_q;
          update_c_d = is_shift;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    rd_d        = (state_d == S_READ);
    wr_d        = (state_d == S_DUMMY_WR) || (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    wdata_d     = 8'h00;
    alu_op_d    = ALU_AND;
    alu_lhs_d   = 8'h00;
    alu_rhs_d   = 8'h00;
    alu_carry_d = 1'b0;

    if (state_d == S_DUMMY_WR) begin
      wdata_d   = operand_d;
      alu_lhs_d = operand_d;
      case (op_d)
        3'd0:    begin alu_op_d = ALU_ASL; alu_carry_d = cin_d; end
        3'd1:    begin alu_op_d = ALU_LSR; alu_carry_d = cin_d; end
        3'd2:    begin alu_op_d = ALU_ROL; alu_carry_d = cin_d; end
        3'd3:    begin alu_op_d = ALU_ROR; alu_carry_d = cin_d; end
        3'd4:    begin alu_op_d = ALU_ADC; alu_rhs_d = 8'h01; end
        default: begin alu_op_d = ALU_ADC; alu_rhs_d = 8'hFF; end
      endcase
    end else if (state_d == S_WRITE) begin
      wdata_d = alu_res_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      addr_q      <= 16'h0000;
      cin_q       <= 1'b0;
      operand_q   <= 8'h00;
      alu_res_q   <= 8'h00;
      alu_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      wdata_q     <= 8'h00;
      alu_op_q    <= ALU_AND;
      alu_lhs_q   <= 8'h00;
      alu_rhs_q   <= 8'h00;
      alu_carry_q <= 1'b0;
      result_q    <= 8'h00;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      update_c_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      cin_q       <= cin_d;
      operand_q   <= operand_d;
      alu_res_q   <= alu_res_d;
      alu_cout_q  <= alu_cout_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      wdata_q     <= wdata_d;
      alu_op_q    <= alu_op_d;
      alu_lhs_q   <= alu_lhs_d;
      alu_rhs_q   <= alu_rhs_d;
      alu_carry_q <= alu_carry_d;
      result_q    <= result_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      update_c_q  <= update_c_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_rd    = rd_q;
  assign o_mem_wr    = wr_q;
  assign o_mem_wdata = wdata_q;
  assign o_alu_op    = alu_op_q;
  assign o_alu_lhs   = alu_lhs_q;
  assign o_alu_rhs   = alu_rhs_q;
  assign o_alu_carry = alu_carry_q;
  assign o_alu_bcd   = 1'b0;
  assign o_done      = done_q;
  assign o_result    = result_q;
  assign o_flag_n    = flag_n_q;
  assign o_flag_z    = flag_z_q;
  assign o_flag_c    = flag_c_q;
  assign o_update_c  = update_c_q;

endmodule

// File: tb/tb_cpu_6502_rmw_seq.sv
// Bench for cpu_6502_rmw_seq: ALU and memory models around the sequencer, random and directed RMW operations.
module tb_cpu_6502_rmw_seq;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_carry, i_mem_ready;
  logic [2:0]  i_op;
  logic [15:0] i_addr;
  logic [7:0]  i_mem_rdata;
  logic        o_busy, o_mem_rd, o_mem_wr, o_alu_carry, o_alu_bcd, o_done;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata, o_alu_lhs, o_alu_rhs, o_result;
  alu_op_t     o_alu_op;
  logic [7:0]  i_alu_result;
  logic        i_alu_carry;
  logic        o_flag_n, o_flag_z, o_flag_c, o_update_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  cpu_6502_rmw_seq dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op), .i_addr(i_addr),
    .i_carry(i_carry), .o_busy(o_busy), .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .i_mem_ready(i_mem_ready), .o_alu_op(o_alu_op), .o_alu_lhs(o_alu_lhs),
    .o_alu_rhs(o_alu_rhs), .o_alu_carry(o_alu_carry), .o_alu_bcd(o_alu_bcd),
    .i_alu_result(i_alu_result), .i_alu_carry(i_alu_carry), .o_done(o_done),
    .o_result(o_result), .o_flag_n(o_flag_n), .o_flag_z(o_flag_z), .o_flag_c(o_flag_c),
    .o_update_c(o_update_c)
  );

  // Stand-in for the downstream ALU.
  always_comb begin
    int s;
    s = 0;
    i_alu_result = 8'h00;
    i_alu_carry  = 1'b0;
    case (o_alu_op)
      ALU_ASL: begin s = int'(o_alu_lhs) * 2; end
      ALU_ROL: begin s = int'(o_alu_lhs) * 2 + int'(o_alu_carry); end
      ALU_LSR: begin s = int'(o_alu_lhs) / 2 + (o_alu_lhs[0] ? 256 : 0); end
      ALU_ROR: begin s = int'(o_alu_lhs) / 2 + int'(o_alu_carry) * 128 + (o_alu_lhs[0] ? 256 : 0); end
      ALU_ADC: begin s = int'(o_alu_lhs) + int'(o_alu_rhs) + int'(o_alu_carry); end
      default: begin s = int'(o_alu_lhs & o_alu_rhs); end
    endcase
    i_alu_result = s[7:0];
    i_alu_carry  = s[8];
  end

  // Reference: {update_c, new C, result} from 6502 RMW semantics.
  function automatic logic [9:0] ref_rmw(input logic [2:0] op, input logic [7:0] v, input logic c);
    int r;
    logic fc;
    case (op)
      3'd0:    begin r = int'(v) * 2;                   fc = v[7]; end
      3'd1:    begin r = int'(v) / 2;                   fc = v[0]; end
      3'd2:    begin r = int'(v) * 2 + int'(c);         fc = v[7]; end
      3'd3:    begin r = int'(v) / 2 + int'(c) * 128;   fc = v[0]; end
      3'd4:    begin r = int'(v) + 1;                   fc = c;    end
      default: begin r = int'(v) + 255;                 fc = c;    end
    endcase
    r = r % 256;
    return {(op < 3'd4), fc, r[7:0]};
  endfunction

  // Observations from the most recent run_op
  int         obs_rd_cnt, obs_wr_cnt, obs_done_cnt, obs_done_cyc, obs_busy_cnt;
  int         obs_both, obs_unstable, obs_addr_bad, obs_alu_bad, obs_hold_bad;
  logic [15:0] obs_rd_addr;
  logic [7:0]  obs_wr [4];
  logic [11:0] obs_flags;

  task automatic run_op(input logic [2:0] op, input logic [15:0] addr, input logic c,
                        input logic [7:0] v, input int st_rd, input int st_dw, input int st_wr,
                        input bit poke_start);
    int waits, limit;
    bit stalled, poked, access;
    logic p_rd, p_wr;
    logic [15:0] p_addr;
    logic [7:0] p_wdata;
    obs_rd_cnt = 0; obs_wr_cnt = 0; obs_done_cnt = 0; obs_done_cyc = -1; obs_busy_cnt = 0;
    obs_both = 0; obs_unstable = 0; obs_addr_bad = 0; obs_alu_bad = 0; obs_hold_bad = 0;
    obs_rd_addr = 16'h0; obs_flags = 12'h0;
    for (int k = 0; k < 4; k++) obs_wr[k] = 8'h00;
    waits = 0; stalled = 0; poked = 0;
    p_rd = 0; p_wr = 0; p_addr = 0; p_wdata = 0;
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_addr = addr; i_carry = c;
    i_mem_ready = 1'b1; i_mem_rdata = 8'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_op    = 3'($urandom_range(0, 7));
      i_addr  = 16'($urandom);
      i_carry = 1'($urandom);
      if (poke_start && o_mem_wr && obs_wr_cnt == 0 && !poked) begin
        i_start = 1'b1; i_op = 3'd4; poked = 1;
      end
      if (o_mem_rd && o_mem_wr) obs_both++;
      if (stalled && (o_mem_rd !== p_rd || o_mem_wr !== p_wr ||
                      o_mem_addr !== p_addr || o_mem_wdata !== p_wdata)) obs_unstable++;
      if ((o_mem_rd || o_mem_wr) && o_mem_addr !== addr) obs_addr_bad++;
      if (o_busy) obs_busy_cnt++;
      if (o_alu_bcd !== 1'b0) obs_alu_bad++;
      if (!(o_mem_wr && obs_wr_cnt == 0) &&
          (o_alu_op !== ALU_AND || o_alu_lhs !== 8'h00 || o_alu_rhs !== 8'h00 || o_alu_carry !== 1'b0))
        obs_alu_bad++;
      if (obs_done_cnt > 0 &&
          {o_update_c, o_flag_c, o_flag_z, o_flag_n, o_result} !== obs_flags) obs_hold_bad++;
      if (o_done) begin
        obs_done_cnt++;
        if (obs_done_cnt == 1) begin
          obs_done_cyc = cyc;
          obs_flags = {o_update_c, o_flag_c, o_flag_z, o_flag_n, o_result};
        end
      end
      i_mem_ready = 1'b1;
      i_mem_rdata = 8'($urandom);
      access = o_mem_rd || o_mem_wr;
      limit  = o_mem_rd ? st_rd : (obs_wr_cnt == 0 ? st_dw : st_wr);
      if (access) begin
        if (waits < limit) begin
          i_mem_ready = 1'b0;
          waits++;
        end else begin
          waits = 0;
          if (o_mem_rd) begin
            i_mem_rdata = v;
            obs_rd_cnt++;
            obs_rd_addr = o_mem_addr;
          end else begin
            if (obs_wr_cnt < 4) obs_wr[obs_wr_cnt] = o_mem_wdata;
            obs_wr_cnt++;
          end
        end
      end
      stalled = access && !i_mem_ready;
      p_rd = o_mem_rd; p_wr = o_mem_wr; p_addr = o_mem_addr; p_wdata = o_mem_wdata;
      if (obs_done_cnt > 0 && cyc >= obs_done_cyc + 3) break;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_start = 1'b0; i_op = 3'd0; i_addr = 16'h0; i_carry = 1'b0;
    i_mem_ready = 1'b1; i_mem_rdata = 8'h00;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    n_vec++;
    if ({o_busy, o_mem_rd, o_mem_wr, o_done, o_update_c, o_flag_n, o_flag_z, o_flag_c, o_alu_carry, o_alu_bcd} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_bits got %b want 0", {o_busy, o_mem_rd, o_mem_wr, o_done, o_update_c, o_flag_n, o_flag_z, o_flag_c, o_alu_carry, o_alu_bcd});
    end
    n_vec++;
    if ({o_mem_addr, o_mem_wdata, o_result, o_alu_lhs, o_alu_rhs} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data got %h want 0", {o_mem_addr, o_mem_wdata, o_result, o_alu_lhs, o_alu_rhs});
    end
    n_vec++;
    if (o_alu_op !== ALU_AND) begin
      n_err++;
      $display("FAIL reset_alu_op got %0d want %0d", o_alu_op, ALU_AND);
    end
  endtask

  task automatic test_directed;
    logic [2:0]  t_op [6] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd2, 3'd1};
    logic [15:0] t_ad [6] = '{16'h0200, 16'h1234, 16'h00FF, 16'h8000, 16'h4321, 16'hFFFF};
    logic        t_c  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  t_v  [6] = '{8'h81, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h01};
    int          t_sr [6] = '{0, 0, 0, 0, 3, 0};
    int          t_sd [6] = '{0, 0, 0, 0, 0, 1};
    int          t_sw [6] = '{0, 0, 0, 0, 2, 0};
    for (int i = 0; i < 6; i++) begin
      logic [9:0] e;
      int ecyc;
      e = ref_rmw(t_op[i], t_v[i], t_c[i]);
      ecyc = 4 + t_sr[i] + t_sd[i] + t_sw[i];
      run_op(t_op[i], t_ad[i], t_c[i], t_v[i], t_sr[i], t_sd[i], t_sw[i], 1'b0);
      n_vec++;
      if (obs_rd_cnt != 1 || obs_rd_addr !== t_ad[i]) begin
        n_err++;
        $display("FAIL dir%0d_read got cnt=%0d addr=%h want cnt=1 addr=%h", i, obs_rd_cnt, obs_rd_addr, t_ad[i]);
      end
      n_vec++;
      if (obs_wr_cnt != 2 || obs_wr[0] !== t_v[i] || obs_wr[1] !== e[7:0]) begin
        n_err++;
        $display("FAIL dir%0d_writes got cnt=%0d %h,%h want cnt=2 %h,%h", i, obs_wr_cnt, obs_wr[0], obs_wr[1], t_v[i], e[7:0]);
      end
      n_vec++;
      if (obs_done_cyc != ecyc || obs_done_cnt != 1 || obs_busy_cnt != ecyc) begin
        n_err++;
        $display("FAIL dir%0d_timing got done_cyc=%0d dones=%0d busy=%0d want %0d,1,%0d", i, obs_done_cyc, obs_done_cnt, obs_busy_cnt, ecyc, ecyc);
      end
      n_vec++;
      if (obs_flags !== {e[9], e[8], (e[7:0] == 8'h00), e[7], e[7:0]}) begin
        n_err++;
        $display("FAIL dir%0d_flags got upd,c,z,n,res=%h want %h", i, obs_flags, {e[9], e[8], (e[7:0] == 8'h00), e[7], e[7:0]});
      end
      n_vec++;
      if (obs_both + obs_unstable + obs_addr_bad + obs_alu_bad + obs_hold_bad != 0) begin
        n_err++;
        $display("FAIL dir%0d_protocol got both=%0d unstable=%0d addr=%0d alu=%0d hold=%0d want all 0", i, obs_both, obs_unstable, obs_addr_bad, obs_alu_bad, obs_hold_bad);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [2:0] op;
      logic [15:0] ad;
      logic c;
      logic [7:0] v;
      logic [9:0] e;
      int sr, sd, sw;
      op = 3'($urandom_range(0, 5)); ad = 16'($urandom); c = 1'($urandom); v = 8'($urandom);
      sr = $urandom_range(0, 2); sd = $urandom_range(0, 2); sw = $urandom_range(0, 2);
      e = ref_rmw(op, v, c);
      run_op(op, ad, c, v, sr, sd, sw, 1'b0);
      n_vec++;
      if (obs_wr_cnt != 2 || obs_wr[0] !== v || obs_wr[1] !== e[7:0] || obs_rd_cnt != 1) begin
        n_err++;
        $display("FAIL rnd%0d_bus op=%0d got rd=%0d wr=%0d %h,%h want 1,2 %h,%h", i, op, obs_rd_cnt, obs_wr_cnt, obs_wr[0], obs_wr[1], v, e[7:0]);
      end
      n_vec++;
      if (obs_done_cyc != 4 + sr + sd + sw || obs_done_cnt != 1) begin
        n_err++;
        $display("FAIL rnd%0d_timing got done_cyc=%0d dones=%0d want %0d,1", i, obs_done_cyc, obs_done_cnt, 4 + sr + sd + sw);
      end
      n_vec++;
      if (obs_flags !== {e[9], e[8], (e[7:0] == 8'h00), e[7], e[7:0]}) begin
        n_err++;
        $display("FAIL rnd%0d_flags op=%0d v=%h c=%b got %h want %h", i, op, v, c, obs_flags, {e[9], e[8], (e[7:0] == 8'h00), e[7], e[7:0]});
      end
      n_vec++;
      if (obs_both + obs_unstable + obs_addr_bad + obs_alu_bad + obs_hold_bad != 0) begin
        n_err++;
        $display("FAIL rnd%0d_protocol got both=%0d unstable=%0d addr=%0d alu=%0d hold=%0d want all 0", i, obs_both, obs_unstable, obs_addr_bad, obs_alu_bad, obs_hold_bad);
      end
    end
  endtask

  task automatic test_ignored_starts;
    int activity;
    logic [9:0] e;
    activity = 0;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 3'd6; i_addr = 16'h1111; i_mem_ready = 1'b1;
    @(negedge i_clk);
    if (o_busy || o_mem_rd || o_mem_wr) activity++;
    i_op = 3'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_busy || o_mem_rd || o_mem_wr || o_done) activity++;
    end
    n_vec++;
    if (activity != 0) begin
      n_err++;
      $display("FAIL reserved_op_start got active_cycles=%0d want 0", activity);
    end
    e = ref_rmw(3'd2, 8'h55, 1'b1);
    run_op(3'd2, 16'h0300, 1'b1, 8'h55, 0, 0, 0, 1'b1);
    n_vec++;
    if (obs_rd_cnt != 1 || obs_wr_cnt != 2 || obs_done_cnt != 1 || obs_wr[1] !== e[7:0]) begin
      n_err++;
      $display("FAIL busy_start got rd=%0d wr=%0d done=%0d res=%h want 1,2,1,%h", obs_rd_cnt, obs_wr_cnt, obs_done_cnt, obs_wr[1], e[7:0]);
    end
  endtask

  task automatic test_reset_midop;
    int guard, activity;
    logic [9:0] e;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 3'd0; i_addr = 16'h0400; i_carry = 1'b0;
    i_mem_ready = 1'b1; i_mem_rdata = 8'h3C;
    guard = 0;
    do begin
      @(negedge i_clk);
      i_start = 1'b0;
      guard++;
    end while (!o_mem_wr && guard < 10);
    n_vec++;
    if (!o_mem_wr) begin
      n_err++;
      $display("FAIL reset_mid_reach got wr=%b want 1 within 10 cycles", o_mem_wr);
    end
    i_mem_ready = 1'b0;
    #1 i_reset = 1'b1;
    #1;
    n_vec++;
    if ({o_mem_wr, o_mem_rd, o_busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid_async got wr,rd,busy=%b want 000", {o_mem_wr, o_mem_rd, o_busy});
    end
    @(negedge i_clk);
    i_reset = 1'b0; i_mem_ready = 1'b1;
    activity = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_mem_wr || o_mem_rd || o_done || o_busy) activity++;
    end
    n_vec++;
    if (activity != 0) begin
      n_err++;
      $display("FAIL reset_mid_after got active_cycles=%0d want 0", activity);
    end
    e = ref_rmw(3'd5, 8'h10, 1'b0);
    run_op(3'd5, 16'h0401, 1'b0, 8'h10, 0, 0, 0, 1'b0);
    n_vec++;
    if (obs_done_cyc != 4 || obs_wr_cnt != 2 || obs_wr[1] !== e[7:0]) begin
      n_err++;
      $display("FAIL reset_mid_fresh got done_cyc=%0d wr=%0d res=%h want 4,2,%h", obs_done_cyc, obs_wr_cnt, obs_wr[1], e[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd_m, wr_m, done_m, busy_m;
    rd_m = 0; wr_m = 0; done_m = 0; busy_m = 0;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 3'd4; i_addr = 16'h0500; i_carry = 1'b0;
    i_mem_ready = 1'b1; i_mem_rdata = 8'h7F;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge i_clk);
      rd_m[cyc] = o_mem_rd; wr_m[cyc] = o_mem_wr; done_m[cyc] = o_done; busy_m[cyc] = o_busy;
      if (cyc == 10) i_start = 1'b0;
    end
    n_vec++;
    if (rd_m !== 16'h0042 || wr_m !== 16'h018C) begin
      n_err++;
      $display("FAIL b2b_bus got rd=%h wr=%h want 0042 018c", rd_m, wr_m);
    end
    n_vec++;
    if (done_m !== 16'h0210 || busy_m !== 16'h03DE) begin
      n_err++;
      $display("FAIL b2b_ctrl got done=%h busy=%h want 0210 03de", done_m, busy_m);
    end
    n_vec++;
    if ({o_result, o_flag_n, o_flag_z, o_update_c} !== {8'h80, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_result got res=%h n=%b z=%b upd=%b want 80 1 0 0", o_result, o_flag_n, o_flag_z, o_update_c);
    end
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_starts();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_6502_rmw_seq.md
# cpu_6502_rmw_seq

Read-modify-write sequencer for the 6502 core's memory-operand shift/rotate and INC/DEC instructions. On a start request it reads the operand byte, performs the 6502 dummy write of the unmodified value, drives the ALU with the latched operand, and writes the ALU result back to the same address. It sits directly upstream of `cpu_6502_alu`, supplying operation, operands and carry-in, and consumes the ALU's result and carry-out. It sits between the decoder/bus arbiter and the flag logic.

## Interface
Parameters:
- none

Ports:
- `i_clk`  in  1  — core clock.
- `i_reset`  in  1  — asynchronous, active-high reset.
- `i_start`  in  1  — start request; sampled only in IDLE.
- `i_op`  in  3  — operation select: 0 ASL, 1 LSR, 2 ROL, 3 ROR, 4 INC, 5 DEC; 6 and 7 are reserved.
- `i_addr`  in  16  — effective operand address; latched on start.
- `i_carry`  in  1  — current C flag; latched on start.
- `o_busy`  out  1  — high in every state except IDLE.
- `o_mem_addr`  out  16  — bus address.
- `o_mem_rd`  out  1  — read strobe.
- `o_mem_wr`  out  1  — write strobe.
- `o_mem_wdata`  out  8  — write data.
- `i_mem_rdata`  in  8  — read data; valid when `i_mem_ready` is high during a read.
- `i_mem_ready`  in  1  — bus accept; while low, the current access stalls.
- `o_alu_op`  out  `alu_op_t`  — operation to the ALU.
- `o_alu_lhs`  out  8  — ALU left operand.
- `o_alu_rhs`  out  8  — ALU right operand.
- `o_alu_carry`  out  1  — ALU carry-in.
- `o_alu_bcd`  out  1  — ALU decimal mode; tied to 0.
- `i_alu_result`  in  8  — ALU result.
- `i_alu_carry`  in  1  — ALU carry-out.
- `o_done`  out  1  — one-cycle completion pulse.
- `o_result`  out  8  — value written back; held until the next start.
- `o_flag_n`  out  1  — N flag = `o_result[7]`; held until the next start.
- `o_flag_z`  out  1  — Z flag = (`o_result` == 0); held until the next start.
- `o_flag_c`  out  1  — new C flag; held until the next start.
- `o_update_c`  out  1  — 1 if C must be written: shifts/rotates yes, INC/DEC no.

## Operation
- States: IDLE → READ → DUMMY_WR → WRITE → DONE → IDLE.
- **IDLE**: if `i_start` is high and `i_op` ≤ 5, latch `i_op`, `i_addr` and `i_carry`, then go to READ. If `i_op` is 6 or 7, ignore the start.
- **READ**:
  - Drive `o_mem_rd`=1 and `o_mem_addr`=latched address.
  - On `i_mem_ready`, latch `i_mem_rdata` as the operand and go to DUMMY_WR.
- **DUMMY_WR**:
  - Drive `o_mem_wr`=1 with `o_mem_wdata`=operand (unmodified) to the same address.
  - The ALU is driven this cycle.
  - On `i_mem_ready`, latch `i_alu_result` and `i_alu_carry` and go to WRITE.
- **WRITE**:
  - Drive `o_mem_wr`=1 with `o_mem_wdata`=latched ALU result.
  - On `i_mem_ready`, go to DONE.
- **DONE**: `o_done`=1 for one cycle, then go to IDLE.
- ALU drive, active in DUMMY_WR only; in all other states ALU outputs are zero and `o_alu_op` = `ALU_AND`:
  - ASL/LSR/ROL/ROR: `o_alu_op`=`ALU_ASL`/`ALU_LSR`/`ALU_ROL`/`ALU_ROR`, lhs=operand, rhs=0x00, carry=latched C.
  - INC: `ALU_ADC`, lhs=operand, rhs=0x01, carry=0.
  - DEC: `ALU_ADC`, lhs=operand, rhs=0xFF, carry=0. The result is operand−1 mod 256.
  - `o_alu_bcd` is always 0, so INC/DEC are binary regardless of the D flag.
- Flags:
  - For shifts, `o_flag_c` = latched ALU carry-out and `o_update_c`=1.
  - For INC/DEC, `o_flag_c` = latched input C (passed through unchanged) and `o_update_c`=0.
- Rules:
  - `o_mem_rd` and `o_mem_wr` are never high together.
  - `o_mem_addr` holds constant from READ through WRITE.
  - `i_start` is ignored while busy.
  - A start is accepted only in IDLE, so back-to-back operations have at least one IDLE cycle between DONE and the next READ.

## Timing
- Reset values:
  - state IDLE;
  - `o_busy`, `o_mem_rd`, `o_mem_wr`, `o_done`, `o_update_c`, flags = 0;
  - `o_mem_addr`, `o_mem_wdata`, `o_result`, ALU operands = 0.
- All outputs are decoded from registered state and latches; no combinational path from `i_start` to any output.
- With `i_mem_ready` held at 1, and `i_start` sampled at edge 0:
  - READ in cycle 1, DUMMY_WR in cycle 2, WRITE in cycle 3;
  - `o_done` in cycle 4, IDLE in cycle 5.
  - `o_busy` is high for cycles 1–4.
- Each cycle with `i_mem_ready` low extends the current state by one cycle. Strobe, address and data are held stable across the stall.
- Reset asserted mid-operation: all strobes and `o_busy` drop asynchronously. No partial write is completed, and no `o_done` is issued.

## Test plan
- ASL, addr 0x0200, rdata 0x81, C=0, ready=1 → read 0x0200; write 0x81; write 0x02; `o_done` in cycle 4; C=1, N=0, Z=0, `o_update_c`=1.
- ROR, rdata 0x01, C=1 → writes 0x01 then 0x80; C=1, N=1, Z=0.
- INC, rdata 0xFF, C=1, D flag irrelevant → writes 0xFF then 0x00; Z=1, N=0, `o_flag_c`=1, `o_update_c`=0. DEC, rdata 0x00 → final write 0xFF, N=1.
- Wait states: ready low 3 cycles in READ and 2 in WRITE → strobes, address and wdata stable throughout; `o_done` in cycle 9; single completion.
- `i_start` pulsed during DUMMY_WR, and `i_op`=6 in IDLE → both ignored; no extra bus cycles.
- Reset asserted during DUMMY_WR → `o_mem_wr` and `o_busy` go to 0 before the next edge; no WRITE or `o_done`; a fresh start after reset completes normally.
